mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 96 +++++++++
 tb/tb_mem_lsu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit; issues one data-memory request per aligned access,
// stalls the pipeline until the ack, then aligns and extends the load result.
`ifndef XLEN_64b
`define XLEN_64b 2
`endif
module mem_lsu #(
    parameter int XLEN = `XLEN_64b,
    localparam int W = 1 << (XLEN + 4),
    localparam int B = W / 8,
    localparam int OW = $clog2(B)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_mem_rd_m,
    input  logic         i_mem_wr_m,
    input  logic [2:0]   i_f3_m,
    input  logic [W-1:0] i_addr_m,
    input  logic [W-1:0] i_wdata_m,
    output logic         o_dmem_req,
    output logic         o_dmem_we,
    output logic [W-1:0] o_dmem_addr,
    output logic [W-1:0] o_dmem_wdata,
    output logic [B-1:0] o_dmem_be,
    input  logic         i_dmem_ack,
    input  logic [W-1:0] i_dmem_rdata,
    output logic [W-1:0] o_mem_out_m,
    output logic         o_stall,
    output logic         o_misaligned
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;
    logic access, misaligned_acc, start;
    logic [OW-1:0] off, off_q;
    logic [1:0] size_q;
    logic uns_q;
    int unsigned nbytes;
    logic [B-1:0] mask;
    logic [W-1:0] shifted, load_val;

    assign access = i_mem_rd_m | i_mem_wr_m;
    assign off = i_addr_m[OW-1:0];
    assign nbytes = 32'd1 << i_f3_m[1:0];
    assign misaligned_acc = access && ((nbytes > B) || ((off & OW'(nbytes - 1)) != '0));
    assign start = access && !misaligned_acc;
    // sizes wider than the bus underflow the shift amount and yield an empty mask
    assign mask = {B{1'b1}} >> (B - nbytes);
    assign shifted = i_dmem_rdata >> {off_q, 3'b000};
    assign load_val = size_q == 2'd0 ? W'(shifted[7:0])  | ({W{~uns_q & shifted[7]}}  << 8)  :
                      size_q == 2'd1 ? W'(shifted[15:0]) | ({W{~uns_q & shifted[15]}} << 16) :
                      size_q == 2'd2 ? W'(shifted[31:0]) | ({W{~uns_q & shifted[31]}} << 32) :
                      shifted;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_stall = 1'b0;
        o_misaligned = 1'b0;
        state_nxt = state == IDLE ? (start ? BUSY : IDLE) :
                    state == BUSY ? (i_dmem_ack ? DONE : BUSY) : IDLE;
        o_stall = (state == IDLE && start) || state == BUSY;
        o_misaligned = state == IDLE && misaligned_acc;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_dmem_req <= 1'b0;
            o_dmem_we <= 1'b0;
            o_dmem_addr <= '0;
            o_dmem_wdata <= '0;
            o_dmem_be <= '0;
            o_mem_out_m <= '0;
            off_q <= '0;
            size_q <= '0;
            uns_q <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                o_dmem_req <= 1'b1;
                o_dmem_we <= i_mem_wr_m;
                o_dmem_addr <= {i_addr_m[W-1:OW], OW'(0)};
                o_dmem_wdata <= i_wdata_m << {off, 3'b000};
                o_dmem_be <= mask << off;
                off_q <= off;
                size_q <= i_f3_m[1:0];
                uns_q <= i_f3_m[2];
            end
            if (state == BUSY && i_dmem_ack) begin
                o_dmem_req <= 1'b0;
                if (!o_dmem_we) o_mem_out_m <= load_val;
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench with a transaction-level expectation model checked every cycle.
module tb_mem_lsu;
    logic clk = 1'b0, rst_n;
    logic rd, wr, ack;
    logic [2:0] f3;
    logic [63:0] addr, wdata, rdata;
    logic req, we, stall, mis;
    logic [63:0] d_addr, d_wdata, mem_out;
    logic [7:0] be;

    mem_lsu dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_rd_m(rd), .i_mem_wr_m(wr), .i_f3_m(f3),
        .i_addr_m(addr), .i_wdata_m(wdata), .o_dmem_req(req), .o_dmem_we(we),
        .o_dmem_addr(d_addr), .o_dmem_wdata(d_wdata), .o_dmem_be(be), .i_dmem_ack(ack),
        .i_dmem_rdata(rdata), .o_mem_out_m(mem_out), .o_stall(stall), .o_misaligned(mis)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, n_req = 0;
    bit chk_en = 0, exp_zero = 0, exp_stall, exp_mis, exp_req, exp_we, rec = 0, prev_req = 0;
    logic [63:0] exp_addr, exp_wdata, exp_mem, last_addr, last_wdata;
    logic [7:0] exp_be, last_be;
    bit last_we;
    logic [31:0] shist, mhist;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic bit m_mis(input bit [2:0] fn, input bit [63:0] a);
        int nb = 1 << fn[1:0];
        return (a % nb) != 0 || nb > 8;
    endfunction

    function automatic bit [7:0] m_be(input bit [2:0] fn, input int off);
        bit [63:0] m = ((64'd1 << (1 << fn[1:0])) - 64'd1) << off;
        return m[7:0];
    endfunction

    function automatic bit [63:0] m_load(input bit [63:0] r, input int off, input bit [2:0] fn);
        bit [63:0] v = r >> (8 * off);
        int nb = 1 << fn[1:0];
        if (nb < 8) begin
            bit [63:0] lim = 64'd1 << (8 * nb);
            v = v % lim;
            if (!fn[2] && v >= (lim >> 1)) v = v - lim;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", stall, exp_stall);
            chk("misaligned", mis, exp_mis);
            chk("req", req, exp_req);
            chk("mem_out", mem_out, exp_mem);
            if (exp_req || exp_zero) begin
                chk("addr", d_addr, exp_addr);
                chk("be", be, exp_be);
                chk("we", we, exp_we);
                chk("wdata", d_wdata, exp_wdata);
            end
            if (req && !prev_req) n_req++;
            prev_req = req;
            if (req) begin
                last_addr = d_addr; last_be = be; last_we = we; last_wdata = d_wdata;
            end
            if (rec) begin
                shist = {shist[30:0], stall};
                mhist = {mhist[30:0], mis};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rd = 0; wr = 0; f3 = 0; addr = 0; wdata = 0; ack = 0; rdata = 0;
        exp_stall = 0; exp_mis = 0; exp_req = 0;
    endtask

    task automatic zero_fields();
        exp_zero = 1; exp_addr = 0; exp_be = 0; exp_we = 0; exp_wdata = 0;
    endtask

    task automatic access(input bit r, input bit w, input bit [2:0] fn, input bit [63:0] a,
                          input bit [63:0] wd, input bit [63:0] rdat, input int d);
        int off = int'(a % 8);
        bit m = m_mis(fn, a);
        rd = r; wr = w; f3 = fn; addr = a; wdata = wd; ack = 0; rdata = 0;
        exp_stall = !m; exp_mis = m; exp_req = 0;
        step();
        if (m) begin
            set_idle();
            return;
        end
        exp_zero = 0;
        exp_req = 1; exp_addr = a - 64'(off); exp_be = m_be(fn, off); exp_we = w;
        exp_wdata = wd << (8 * off);
        for (int i = 0; i <= d; i++) begin
            ack = (i == d);
            rdata = (i == d) ? rdat : ~rdat;
            step();
        end
        exp_req = 0; exp_stall = 0; exp_mis = 0;
        if (!w) exp_mem = m_load(rdat, off, fn);
        ack = 1; rdata = ~rdat;
        step();
        set_idle();
    endtask

    task automatic start_rec();
        rec = 1; shist = 0; mhist = 0;
    endtask

    initial begin
        int nr;
        rst_n = 0; set_idle(); exp_mem = 0; zero_fields();
        step(); step();
        chk_en = 1;
        step();
        rst_n = 1;
        step(); step();

        start_rec();
        access(1, 0, 3'b010, 64'h1004, 0, 64'hDEADBEEF_00000000, 0);
        rec = 0;
        chk("lw_out", mem_out, 64'hFFFFFFFF_DEADBEEF);
        chk("lw_be", last_be, 8'hF0);
        chk("lw_addr", last_addr, 64'h1000);
        chk("lw_stall", shist[2:0], 3'b110);

        access(1, 0, 3'b100, 64'h1003, 0, 64'h00000000_80000000, 0);
        chk("lbu_out", mem_out, 64'h00000000_00000080);
        access(1, 0, 3'b000, 64'h1003, 0, 64'h00000000_80000000, 1);
        chk("lb_out", mem_out, 64'hFFFFFFFF_FFFFFF80);

        access(0, 1, 3'b001, 64'h2002, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        chk("sh_we", last_we, 1);
        chk("sh_be", last_be, 8'h0C);
        chk("sh_wdata", last_wdata, 64'h00000000_12340000);
        chk("sh_keep", mem_out, 64'hFFFFFFFF_FFFFFF80);

        nr = n_req;
        start_rec();
        access(1, 0, 3'b010, 64'h1002, 0, 0, 0);
        rec = 0;
        chk("lw_mis_flag", mhist[0], 1);
        chk("lw_mis_stall", shist[0], 0);
        chk("lw_mis_noreq", n_req, nr);
        access(1, 0, 3'b011, 64'h1004, 0, 0, 0);
        access(0, 1, 3'b000, 64'h1007, 64'hA5, 0, 0);
        chk("sb_be", last_be, 8'h80);
        access(1, 0, 3'b101, 64'h1006, 0, 64'hBEEF_0000_0000_0000, 2);
        access(1, 1, 3'b010, 64'h5004, 64'h0BAD_F00D, 64'h1111, 0);
        chk("rdwr_is_store", last_we, 1);

        start_rec();
        access(1, 0, 3'b011, 64'h3000, 0, 64'h01234567_89ABCDEF, 5);
        rec = 0;
        chk("ld_slow_out", mem_out, 64'h01234567_89ABCDEF);
        chk("ld_slow_stall", $countones(shist), 7);

        rd = 1; wr = 0; f3 = 3'b011; addr = 64'h6000; wdata = 0;
        exp_stall = 1; exp_req = 0;
        step();
        exp_zero = 0;
        exp_req = 1; exp_addr = 64'h6000; exp_be = 8'hFF; exp_we = 0; exp_wdata = 0;
        rst_n = 0;
        step();
        rst_n = 1; set_idle(); zero_fields(); exp_mem = 0;
        step();
        ack = 1; rdata = 64'h7777;
        step();
        ack = 0; rdata = 0;
        step();
        chk("rst_busy_req", req, 0);
        chk("rst_busy_out", mem_out, 0);

        nr = n_req;
        start_rec();
        access(1, 0, 3'b011, 64'h4008, 0, 64'hCAFEF00D_12345678, 0);
        access(0, 1, 3'b011, 64'h4010, 64'h55AA_55AA_0000_FFFF, 0, 0);
        rec = 0;
        chk("b2b_stall", shist[5:0], 6'b110110);
        chk("b2b_nreq", n_req, nr + 2);
        chk("b2b_out", mem_out, 64'hCAFEF00D_12345678);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
